// File: rtl/ddbb256_enum_pkg.sv
// Shared types and constants for the 256-bit config-space enumeration controller.
// No logic: state encoding, row/lane positions and address/lane helpers.
package ddbb256_enum_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_ID,
      ST_WT_ID,
      ST_SZ_WR,
      ST_SZ_RD,
      ST_SZ_WT,
      ST_CALC,
      ST_BAR_WR,
      ST_CMD_WR,
      ST_IRQ_WR,
      ST_NEXT,
      ST_DONE
   } enum_state_t;

   localparam logic [3:0] ROW_HDR = 4'h0;
   localparam logic [3:0] ROW_IRQ = 4'h1;

   // Byte-lane positions inside the 256-bit row
   localparam int LANE_CMD  = 8;
   localparam int LANE_IRQ  = 12;
   localparam int LANE_BAR0 = 16;
   localparam int LANE_BAR1 = 20;
   localparam int LANE_BAR2 = 24;

   localparam logic [15:0] VENDOR_ABSENT = 16'hFFFF;

   function automatic logic [31:0] lane_sel(input int first, input int nbytes);
      logic [31:0] s;
      s = '0;
      for (int i = 0; i < 32; i++) begin
         if (i >= first && i < first + nbytes) s[i] = 1'b1;
      end
      return s;
   endfunction

   function automatic logic [31:0] cfg_adr(input logic [7:0] bus,
                                           input logic [4:0] dev,
                                           input logic [3:0] row);
      logic [31:0] a;
      a        = '0;
      a[27:20] = bus;
      a[19:15] = dev;
      a[8:5]   = row;
      return a;
   endfunction

endpackage

// File: rtl/ddbb256_bar_alloc.sv
// Combinational BAR allocator: aligns next-address up to the BAR size and checks the window.
// Zero latency; a zero mask means an unimplemented BAR and leaves next-address untouched.
module ddbb256_bar_alloc (
   input  logic [31:0] next_addr,
   input  logic [31:0] mask,
   input  logic [31:0] mem_limit,
   output logic [31:0] base,
   output logic [31:0] next_new,
   output logic        ovf
);

   logic [32:0] align_sum;
   logic [31:0] aligned;
   logic [31:0] size;
   logic [32:0] end_sum;
   logic [32:0] last_addr;

   always_comb begin
      align_sum = {1'b0, next_addr} + {1'b0, ~mask};
      aligned   = align_sum[31:0] & mask;
      size      = ~mask + 32'd1;
      end_sum   = {1'b0, aligned} + {1'b0, size};
      last_addr = end_sum - 33'd1;

      base     = '0;
      next_new = next_addr;
      ovf      = 1'b0;
      if (mask != '0) begin
         // A carry out of the round-up means the aligned base wrapped past 4 GiB
         if (align_sum[32] || (last_addr > {1'b0, mem_limit})) begin
            ovf = 1'b1;
         end else begin
            base     = aligned;
            next_new = end_sum[31:0];
         end
      end
   end

endmodule

// File: rtl/ddbb256_cfg_enum.sv
// Config-space enumeration: scans one bus, sizes/assigns BAR0-2, writes command and IRQ line.
// Outputs registered and aligned with the state; reads expect data exactly one cycle after the strobe.
module ddbb256_cfg_enum
   import ddbb256_enum_pkg::*;
#(
   parameter logic [7:0]  CFG_BUS   = 8'd0,
   parameter int          NUM_DEV   = 32,
   parameter logic [31:0] MEM_BASE  = 32'h4000_0000,
   parameter logic [31:0] MEM_LIMIT = 32'h7FFF_FFFF,
   parameter logic [7:0]  CMD_VAL   = 8'h06
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o,
   output logic [31:0]  dev_found_o,
   output logic         cs_config_o,
   output logic         we_o,
   output logic [31:0]  sel_o,
   output logic [31:0]  adr_o,
   output logic [255:0] dat_o,
   input  logic [255:0] dat_i
);

   localparam logic [4:0]  LAST_DEV = 5'(NUM_DEV - 1);
   localparam logic [31:0] SEL_BARS = lane_sel(LANE_BAR0, 12);
   localparam logic [31:0] SEL_CMD  = lane_sel(LANE_CMD, 1);
   localparam logic [31:0] SEL_IRQ  = lane_sel(LANE_IRQ, 1);

   enum_state_t     state_q, state_d;
   logic [4:0]      dev_q, dev_d;
   logic [1:0]      calc_idx_q, calc_idx_d;
   logic [31:0]     next_addr_q, next_addr_d;
   logic [2:0][31:0] mask_q, mask_d;
   logic [2:0][31:0] base_q, base_d;
   logic            failed_q, failed_d;
   logic            err_d;
   logic [31:0]     found_d;
   logic            busy_d, done_d, cs_d, we_d;
   logic [31:0]     sel_d, adr_d;
   logic [255:0]    dat_d;

   logic [31:0]     alloc_mask;
   logic [31:0]     alloc_base;
   logic [31:0]     alloc_next;
   logic            alloc_ovf;
   logic            unused_dat;

   assign unused_dat = ^{dat_i[255:224], dat_i[127:16]};

   ddbb256_bar_alloc u_bar_alloc (
      .next_addr (next_addr_q),
      .mask      (alloc_mask),
      .mem_limit (MEM_LIMIT),
      .base      (alloc_base),
      .next_new  (alloc_next),
      .ovf       (alloc_ovf)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         dev_q       <= '0;
         calc_idx_q  <= '0;
         next_addr_q <= '0;
         mask_q      <= '0;
         base_q      <= '0;
         failed_q    <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         dev_found_o <= '0;
         cs_config_o <= 1'b0;
         we_o        <= 1'b0;
         sel_o       <= '0;
         adr_o       <= '0;
         dat_o       <= '0;
      end else begin
         state_q     <= state_d;
         dev_q       <= dev_d;
         calc_idx_q  <= calc_idx_d;
         next_addr_q <= next_addr_d;
         mask_q      <= mask_d;
         base_q      <= base_d;
         failed_q    <= failed_d;
         busy_o      <= busy_d;
         done_o      <= done_d;
         err_o       <= err_d;
         dev_found_o <= found_d;
         cs_config_o <= cs_d;
         we_o        <= we_d;
         sel_o       <= sel_d;
         adr_o       <= adr_d;
         dat_o       <= dat_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      dev_d       = dev_q;
      calc_idx_d  = calc_idx_q;
      next_addr_d = next_addr_q;
      mask_d      = mask_q;
      base_d      = base_q;
      failed_d    = failed_q;
      err_d       = err_o;
      found_d     = dev_found_o;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      cs_d        = 1'b0;
      we_d        = 1'b0;
      sel_d       = '0;
      adr_d       = '0;
      dat_d       = '0;

      case (calc_idx_q)
         2'd1:    alloc_mask = mask_q[1];
         2'd2:    alloc_mask = mask_q[2];
         default: alloc_mask = mask_q[0];
      endcase

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d     = ST_RD_ID;
               dev_d       = '0;
               err_d       = 1'b0;
               found_d     = '0;
               next_addr_d = MEM_BASE;
            end
         end
         ST_RD_ID: state_d = ST_WT_ID;
         ST_WT_ID: begin
            if (dat_i[15:0] == VENDOR_ABSENT) begin
               state_d = ST_NEXT;
            end else begin
               found_d[dev_q] = 1'b1;
               failed_d       = 1'b0;
               state_d        = ST_SZ_WR;
            end
         end
         ST_SZ_WR: state_d = ST_SZ_RD;
         ST_SZ_RD: state_d = ST_SZ_WT;
         ST_SZ_WT: begin
            mask_d[0]  = dat_i[LANE_BAR0*8 +: 32];
            mask_d[1]  = dat_i[LANE_BAR1*8 +: 32];
            mask_d[2]  = dat_i[LANE_BAR2*8 +: 32];
            calc_idx_d = 2'd0;
            state_d    = ST_CALC;
         end
         ST_CALC: begin
            case (calc_idx_q)
               2'd1:    base_d[1] = alloc_base;
               2'd2:    base_d[2] = alloc_base;
               default: base_d[0] = alloc_base;
            endcase
            next_addr_d = alloc_next;
            if (alloc_ovf) begin
               err_d    = 1'b1;
               failed_d = 1'b1;
            end
            if (calc_idx_q == 2'd2) state_d = ST_BAR_WR;
            else                    calc_idx_d = calc_idx_q + 2'd1;
         end
         ST_BAR_WR: state_d = ST_CMD_WR;
         ST_CMD_WR: state_d = ST_IRQ_WR;
         ST_IRQ_WR: state_d = ST_NEXT;
         ST_NEXT: begin
            if (dev_q == LAST_DEV) begin
               state_d = ST_DONE;
            end else begin
               dev_d   = dev_q + 5'd1;
               state_d = ST_RD_ID;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Output registers are loaded from the state being entered so bus strobes line up with it
      busy_d = (state_d != ST_IDLE);
      case (state_d)
         ST_RD_ID, ST_SZ_RD: begin
            cs_d  = 1'b1;
            adr_d = cfg_adr(CFG_BUS, dev_d, ROW_HDR);
         end
         ST_SZ_WR: begin
            cs_d  = 1'b1;
            we_d  = 1'b1;
            adr_d = cfg_adr(CFG_BUS, dev_d, ROW_HDR);
            sel_d = SEL_BARS;
            dat_d[LANE_BAR0*8 +: 96] = '1;
         end
         ST_BAR_WR: begin
            cs_d  = 1'b1;
            we_d  = 1'b1;
            adr_d = cfg_adr(CFG_BUS, dev_d, ROW_HDR);
            sel_d = SEL_BARS;
            dat_d[LANE_BAR0*8 +: 32] = base_d[0];
            dat_d[LANE_BAR1*8 +: 32] = base_d[1];
            dat_d[LANE_BAR2*8 +: 32] = base_d[2];
         end
         ST_CMD_WR: begin
            cs_d  = 1'b1;
            we_d  = 1'b1;
            adr_d = cfg_adr(CFG_BUS, dev_d, ROW_HDR);
            sel_d = SEL_CMD;
            // A device with an unplaceable BAR keeps memory decode off but may still master
            dat_d[LANE_CMD*8 +: 8] = failed_d ? (CMD_VAL & 8'hFD) : CMD_VAL;
         end
         ST_IRQ_WR: begin
            cs_d  = 1'b1;
            we_d  = 1'b1;
            adr_d = cfg_adr(CFG_BUS, dev_d, ROW_IRQ);
            sel_d = SEL_IRQ;
            dat_d[LANE_IRQ*8 +: 8] = {3'b000, dev_d};
         end
         ST_DONE: done_d = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ddbb256_cfg_enum.sv
// Self-checking bench: config-bus device model, write scoreboard, table of scan scenarios.
// A second instance with a narrow window covers the overflow path.
module tb_ddbb256_cfg_enum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         busy, done, err, cs, we;
   logic [31:0]  found, sel, adr;
   logic [255:0] dat, rd = '1;

   logic         l_start = 1'b0;
   logic         l_busy, l_done, l_err, l_cs, l_we;
   logic [31:0]  l_found, l_sel, l_adr;
   logic [255:0] l_dat, l_rd = '1;

   ddbb256_cfg_enum u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
      .err_o(err), .dev_found_o(found), .cs_config_o(cs), .we_o(we), .sel_o(sel),
      .adr_o(adr), .dat_o(dat), .dat_i(rd)
   );

   ddbb256_cfg_enum #(.NUM_DEV(2), .MEM_LIMIT(32'h4000_FFFF)) u_lim (
      .clk_i(clk), .rst_i(rst), .start_i(l_start), .busy_o(l_busy), .done_o(l_done),
      .err_o(l_err), .dev_found_o(l_found), .cs_config_o(l_cs), .we_o(l_we), .sel_o(l_sel),
      .adr_o(l_adr), .dat_o(l_dat), .dat_i(l_rd)
   );

   typedef struct packed {
      logic [31:0]  adr;
      logic [31:0]  sel;
      logic [255:0] dat;
   } wr_t;

   typedef struct packed {
      int          da;
      logic [31:0] ma0, ma1, ma2, ba0, ba1, ba2;
      logic [7:0]  ca;
      int          db;
      logic [31:0] mb0, mb1, mb2, bb0, bb1, bb2;
      logic [7:0]  cb;
      logic [31:0] found;
      logic        err;
   } vec_t;

   int   n_vec = 0;
   int   n_bad = 0;
   wr_t  sb_q[$];
   wr_t  lim_q[$];
   vec_t vt[7];

   logic        present[32];
   logic [31:0] m_mask[32][3];
   logic [255:0] resp, l_resp;
   logic [4:0]  rdev;

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_adr(input int d, input int row);
      return (32'(d) << 15) | (32'(row) << 5);
   endfunction

   // Device model: answers a read on the following cycle, all-ones when nothing decodes
   always @(posedge clk) begin
      resp = '1;
      if (cs && !we) begin
         rdev = adr[19:15];
         if (present[rdev]) begin
            resp = '0;
            resp[15:0]    = 16'h1AB5;
            resp[159:128] = m_mask[rdev][0];
            resp[191:160] = m_mask[rdev][1];
            resp[223:192] = m_mask[rdev][2];
         end
      end
      rd <= resp;
      l_resp = '1;
      if (l_cs && !l_we && l_adr[19:15] == 5'd0) begin
         l_resp = '0;
         l_resp[15:0]    = 16'h1AB5;
         l_resp[159:128] = 32'hFFFE_0000;
      end
      l_rd <= l_resp;
   end

   always @(negedge clk) begin
      wr_t w;
      if (cs && we) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_write: adr %h sel %h", adr, sel);
         end else begin
            w = sb_q.pop_front();
            chk("write", {adr, sel, dat}, w);
         end
      end else if (!cs) begin
         chk("idle_lanes", {we, sel, dat}, '0);
      end
      if (l_cs && l_we) lim_q.push_back({l_adr, l_sel, l_dat});
   end

   task automatic push_dev(input int d, input logic [31:0] b0, b1, b2, input logic [7:0] cmd);
      wr_t w;
      w.adr = mk_adr(d, 0);
      w.sel = 32'h0FFF_0000;
      w.dat = '0;
      w.dat[223:128] = {96{1'b1}};
      sb_q.push_back(w);
      w.dat = '0;
      w.dat[223:128] = {b2, b1, b0};
      sb_q.push_back(w);
      w.sel = 32'h0000_0100;
      w.dat = '0;
      w.dat[71:64] = cmd;
      sb_q.push_back(w);
      w.adr = mk_adr(d, 1);
      w.sel = 32'h0000_1000;
      w.dat = '0;
      w.dat[103:96] = 8'(d);
      sb_q.push_back(w);
   endtask

   task automatic load_vec(input vec_t v, output int npres);
      npres = 0;
      for (int i = 0; i < 32; i++) begin
         present[i] = 1'b0;
         for (int j = 0; j < 3; j++) m_mask[i][j] = '0;
      end
      if (v.da >= 0) begin
         present[v.da] = 1'b1;
         m_mask[v.da][0] = v.ma0; m_mask[v.da][1] = v.ma1; m_mask[v.da][2] = v.ma2;
         push_dev(v.da, v.ba0, v.ba1, v.ba2, v.ca);
         npres++;
      end
      if (v.db >= 0) begin
         present[v.db] = 1'b1;
         m_mask[v.db][0] = v.mb0; m_mask[v.db][1] = v.mb1; m_mask[v.db][2] = v.mb2;
         push_dev(v.db, v.bb0, v.bb1, v.bb2, v.cb);
         npres++;
      end
   endtask

   // Latency counts cycles from the one holding the sampled start to the one showing done
   task automatic run_scan(input int mid_at, input int exp_lat);
      int cyc = 0;
      int lat = 0;
      int ndone = 0;
      @(negedge clk);
      start = 1'b1;
      while (cyc < 2000 && lat == 0) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == 1) begin
            start = 1'b0;
            chk("start_accept", {busy, err, found}, {1'b1, 1'b0, 32'h0});
         end
         if (mid_at != 0 && cyc == mid_at) start = 1'b1;
         if (mid_at != 0 && cyc == mid_at + 1) start = 1'b0;
         if (done) begin
            ndone++;
            lat = cyc;
         end
      end
      chk("done_latency", lat, exp_lat);
      @(posedge clk);
      #1;
      chk("busy_after_done", {busy, done}, 2'b00);
      repeat (4) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      chk("done_pulses", ndone, 1);
   endtask

   task automatic apply(input vec_t v, input int mid_at);
      int npres;
      load_vec(v, npres);
      run_scan(mid_at, 3 * 32 + 9 * npres + 1);
      chk("dev_found", found, v.found);
      chk("err", err, v.err);
      chk("sb_drained", sb_q.size(), 0);
   endtask

   initial begin
      int np, cyc, lat, rd3;
      vt[0] = '{da:2, ma0:32'hFFFF_0000, ma1:32'h0, ma2:32'hFFFF_F000,
                ba0:32'h4000_0000, ba1:32'h0, ba2:32'h4001_0000, ca:8'h06,
                db:-1, mb0:0, mb1:0, mb2:0, bb0:0, bb1:0, bb2:0, cb:0,
                found:32'h0000_0004, err:1'b0};
      vt[1] = '{da:0, ma0:32'hFFFF_F000, ma1:0, ma2:0, ba0:32'h4000_0000, ba1:0, ba2:0, ca:8'h06,
                db:1, mb0:32'hFFFF_0000, mb1:0, mb2:0, bb0:32'h4001_0000, bb1:0, bb2:0, cb:8'h06,
                found:32'h0000_0003, err:1'b0};
      vt[2] = '{da:0, ma0:32'h8000_0000, ma1:0, ma2:0, ba0:0, ba1:0, ba2:0, ca:8'h04,
                db:1, mb0:32'hFFFF_F000, mb1:0, mb2:0, bb0:32'h4000_0000, bb1:0, bb2:0, cb:8'h06,
                found:32'h0000_0003, err:1'b1};
      vt[3] = '{da:5, ma0:0, ma1:0, ma2:0, ba0:0, ba1:0, ba2:0, ca:8'h06,
                db:31, mb0:32'hFFFF_FFF0, mb1:32'hFFFF_FF00, mb2:0,
                bb0:32'h4000_0000, bb1:32'h4000_0100, bb2:0, cb:8'h06,
                found:32'h8000_0020, err:1'b0};
      vt[4] = '{da:-1, ma0:0, ma1:0, ma2:0, ba0:0, ba1:0, ba2:0, ca:0,
                db:-1, mb0:0, mb1:0, mb2:0, bb0:0, bb1:0, bb2:0, cb:0,
                found:32'h0, err:1'b0};
      vt[5] = '{da:0, ma0:32'hC000_0000, ma1:0, ma2:0, ba0:32'h4000_0000, ba1:0, ba2:0, ca:8'h06,
                db:1, mb0:32'hFFFF_F000, mb1:0, mb2:0, bb0:0, bb1:0, bb2:0, cb:8'h04,
                found:32'h0000_0003, err:1'b1};
      vt[6] = '{da:0, ma0:32'hFFFF_F000, ma1:0, ma2:0, ba0:32'h4000_0000, ba1:0, ba2:0, ca:8'h06,
                db:3, mb0:32'hFFFF_0000, mb1:0, mb2:0, bb0:32'h4001_0000, bb1:0, bb2:0, cb:8'h06,
                found:32'h0000_0009, err:1'b0};
      for (int i = 0; i < 32; i++) present[i] = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctrl", {busy, done, err, found, cs, we}, '0);
      chk("reset_bus", {sel, adr, dat[255:0]}, '0);
      chk("reset_lim", {l_busy, l_done, l_err, l_found, l_cs}, '0);
      @(negedge clk);
      rst = 1'b0;

      // Narrow window: the only BAR overflows, scan still completes
      @(negedge clk);
      l_start = 1'b1;
      cyc = 0;
      lat = 0;
      while (cyc < 500 && lat == 0) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == 1) l_start = 1'b0;
         if (l_done) lat = cyc;
      end
      chk("lim_latency", lat, 3 * 2 + 9 + 1);
      chk("lim_err_found", {l_err, l_found}, {1'b1, 32'h1});
      chk("lim_writes", lim_q.size(), 4);
      if (lim_q.size() == 4) begin
         chk("lim_bar_wr", {lim_q[1].sel, lim_q[1].dat}, {32'h0FFF_0000, 256'h0});
         chk("lim_cmd", lim_q[2].dat, 256'h04 << 64);
      end

      for (int i = 0; i < 6; i++) apply(vt[i], (i == 0) ? 40 : 0);

      // Reset while dev 3 sits in SZ_WT, then a clean rescan
      load_vec(vt[6], np);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      rd3 = 0;
      cyc = 0;
      while (cyc < 300 && rd3 < 2) begin
         if (cs && !we && adr[19:15] == 5'd3) rd3++;
         if (rd3 < 2) begin
            @(posedge clk);
            cyc++;
            #1;
         end
      end
      chk("reach_dev3_sz_rd", rd3, 2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midscan_reset_ctrl", {busy, done, err, found, cs, we}, '0);
      chk("midscan_reset_bus", {sel, adr, dat[255:0]}, '0);
      rst = 1'b0;
      sb_q.delete();
      repeat (5) @(posedge clk);
      apply(vt[6], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
